// File: rtl/dmem_lsu.sv
// Byte-addressed little-endian data memory with a load/store unit front end.
// One transaction in flight: IDLE accepts, ACCESS waits then executes, RESP holds.
module dmem_lsu #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0] mem [2**ADDR_BITS];

  logic [ADDR_BITS-1:0] idx;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] ld;
  logic [3:0]  be;
  logic        fault;
  logic        accept;
  logic        exec;
  logic        do_wr;

  assign accept = req_valid && req_ready;
  assign exec   = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign idx    = addr_q[ADDR_BITS-1:0];
  assign do_wr  = exec && we_q && !fault && !rst;

  // Aligned accesses never carry past the top address bit,
  // so checking the base address covers every accessed byte.
  always_comb begin
    fault = |addr_q[31:ADDR_BITS];
    unique case (size_q)
      2'b00:   fault = fault;
      2'b01:   fault = fault | addr_q[0];
      2'b10:   fault = fault | (|addr_q[1:0]);
      default: fault = 1'b1;
    endcase
  end

  always_comb begin
    be = 4'b0000;
    unique case (size_q)
      2'b00:   be = 4'b0001;
      2'b01:   be = 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx + ADDR_BITS'(i)] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign b0 = mem[idx];
  assign b1 = mem[idx + ADDR_BITS'(1)];
  assign b2 = mem[idx + ADDR_BITS'(2)];
  assign b3 = mem[idx + ADDR_BITS'(3)];

  always_comb begin
    ld = 32'h0;
    unique case (size_q)
      2'b00:   ld = {{24{~uns_q & b0[7]}}, b0};
      2'b01:   ld = {{16{~uns_q & b1[7]}}, b1, b0};
      default: ld = {b3, b2, b1, b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
  end

  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      we_d    = req_we;
      size_d  = req_size;
      uns_d   = req_unsigned;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      cnt_d   = 4'(WAIT_CYCLES);
    end
    if ((state_q == ACCESS) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (exec) begin
      err_d   = fault;
      rdata_d = (fault || we_q) ? 32'h0 : ld;
    end
    if (resp_valid && resp_ready) begin
      rdata_d = 32'h0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
- REQ-001: Parameter ADDR_BITS, default 10, byte-address width of the storage (2^ADDR_BITS bytes, little-endian, byte-addressed).
- REQ-002: Parameter WAIT_CYCLES, default 0, extra access cycles inserted before each memory operation (legal range 0..15).
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst  input  1  synchronous active-high reset.
- REQ-005: req_valid  input  1  request present.
- REQ-006: req_ready  output  1  block accepts a request this cycle.
- REQ-007: req_we  input  1  1 = store, 0 = load.
- REQ-008: req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- REQ-009: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- REQ-010: req_addr  input  32  byte address.
- REQ-011: req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- REQ-012: resp_valid  output  1  response present.
- REQ-013: resp_ready  input  1  consumer accepts response.
- REQ-014: resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- REQ-015: resp_err  output  1  request faulted.

Function
- REQ-016: FSM states: IDLE, ACCESS, RESP; exactly one transaction in flight.
- REQ-017: req_ready = 1 only in IDLE; accept when req_valid && req_ready; request fields registered at acceptance, inputs ignored thereafter.
- REQ-018: IDLE -> ACCESS on acceptance; wait counter loaded with WAIT_CYCLES.
- REQ-019: ACCESS: counter decrements each cycle while nonzero; on the edge where counter = 0 the memory operation executes and state -> RESP.
- REQ-020: Latency: with acceptance at edge E, resp_valid first asserts in the cycle after edge E+1+WAIT_CYCLES (WAIT_CYCLES=0: request cycle 0, resp_valid in cycle 2).
- REQ-021: RESP: resp_valid = 1; resp_rdata and resp_err held stable until resp_valid && resp_ready; then -> IDLE; new request accepted no earlier than the following cycle.
- REQ-022: Error conditions: req_size = 11; halfword with addr[0] = 1; word with addr[1:0] != 00; any accessed byte address >= 2^ADDR_BITS (upper bits nonzero).
- REQ-023: Faulted request: no memory write, resp_err = 1, resp_rdata = 0; same latency as a good request.
- REQ-024: Store: writes only the 1, 2 or 4 bytes selected by size at addr..addr+n-1; all other bytes unchanged.
- REQ-025: Load: byte/half read from addr, extended per req_unsigned into bits [31:8]/[31:16]; word returned as-is.
- REQ-026: Store response: resp_valid with resp_rdata = 0, resp_err = 0.
- REQ-027: Load after store to same address returns the stored data (store committed before its response).
- REQ-028: resp_ready held high in RESP completes response in one cycle; resp_ready low stalls indefinitely without state change.

Reset
- REQ-029: rst high at an edge forces state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready = 1 in the cycle after.
- REQ-030: Reset in ACCESS before the execute edge discards the transaction (store not written); reset in RESP drops the response.
- REQ-031: Storage contents not affected by rst.
- REQ-032: rst has priority over acceptance and response handshakes in the same cycle.

Verification
- REQ-033: Store word 0xDEADBEEF @0x10, load word @0x10 -> rdata 0xDEADBEEF, err 0; bytes 0x10..0x13 = EF BE AD DE.
- REQ-034: Then store byte 0x80 @0x11, load signed byte @0x11 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0xDEAD80EF.
- REQ-035: Load half @0x13 -> err 1, rdata 0; store word @0x12 -> err 1, memory unchanged; size 11 -> err 1; addr 0x400 with ADDR_BITS=10 -> err 1.
- REQ-036: WAIT_CYCLES=3: accept at edge 0 -> resp_valid first high in cycle 5; req_ready low cycles 1..5; resp_ready low 4 cycles -> rdata/err stable.
- REQ-037: Store word 0x12345678 @0x20, assert rst in ACCESS with WAIT_CYCLES=3 -> no response, load @0x20 returns prior content; req_ready high cycle after reset.
